obstacle_engine: RTL and testbench

- Per-frame obstacle stage for the DODGE game on the 160x120 display, running alongside the player draw FSM.
- Owns NUM_OBS falling 4x4 obstacles; on each frame pulse it erases, moves and redraws each one as a stream of single-pixel plot requests for the draw mux feeding vga_adapter.
- Detects player/obstacle collision and counts dodged obstacles.

---
 rtl/obstacle_engine.sv | 170 +++++++++++++++++
 tb/tb_obstacle_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_engine.sv
// Obstacle stage for DODGE: each frame erases, moves and redraws NUM_OBS falling 4x4 blocks as a
// one-pixel-per-cycle plot stream, and tracks player collision and the dodged-obstacle score.
module obstacle_engine #(
    parameter int unsigned NUM_OBS    = 4,
    parameter int unsigned FALL_SPEED = 1,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame,
    input  logic       enable,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       hit,
    output logic [7:0] score
);

    localparam int unsigned IdxW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OBS - 1);
    localparam logic [7:0] FallLimit = 8'(SCREEN_H - 4);
    localparam logic [7:0] XSpan = 8'(SCREEN_W - 4);

    typedef enum logic [1:0] {StIdle, StErase, StMove, StDraw} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [7:0]        ox_q [NUM_OBS];
    logic [7:0]        ox_d [NUM_OBS];
    logic [6:0]        oy_q [NUM_OBS];
    logic [6:0]        oy_d [NUM_OBS];
    logic              hit_q, hit_d;
    logic [7:0]        score_q, score_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic [2:0]        colour_q, colour_d;
    logic              plot_q, plot_d;

    logic [7:0]        oy_new, spawn_x, move_x;
    logic [6:0]        move_y;
    logic              respawn, overlap;
    logic [8:0]        px9, py9, ox9, oy9;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Candidate position of the current obstacle after this frame's move.
    assign oy_new  = {1'b0, oy_q[idx_q]} + 8'(FALL_SPEED);
    assign respawn = oy_new > FallLimit;
    assign spawn_x = (lfsr_q >= XSpan) ? lfsr_q - XSpan : lfsr_q;
    assign move_x  = respawn ? spawn_x : ox_q[idx_q];
    assign move_y  = respawn ? 7'd0 : oy_new[6:0];

    assign px9 = {1'b0, player_x};
    assign py9 = {2'b00, player_y};
    assign ox9 = {1'b0, move_x};
    assign oy9 = {2'b00, move_y};
    assign overlap = (ox9 < px9 + 9'd4) && (px9 < ox9 + 9'd4) &&
                     (oy9 < py9 + 9'd4) && (py9 < oy9 + 9'd4);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            hit_q    <= 1'b0;
            score_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            for (int i = 0; i < NUM_OBS; i++) begin
                ox_q[i] <= 8'(16 + 36 * i);
                oy_q[i] <= 7'(i * (SCREEN_H / NUM_OBS));
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            hit_q    <= hit_d;
            score_q  <= score_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        hit_d   = hit_q;
        score_d = score_q;
        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                cnt_d = '0;
                if (frame && enable && !hit_q) begin
                    state_d = StErase;
                end
            end
            StErase: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StMove;
                end
            end
            StMove: begin
                cnt_d       = '0;
                ox_d[idx_q] = move_x;
                oy_d[idx_q] = move_y;
                if (respawn && score_q != 8'hFF) begin
                    score_d = score_q + 8'd1;
                end
                if (overlap) begin
                    hit_d = 1'b1;
                end
                state_d = StDraw;
            end
            StDraw: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StErase;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pixel registers are loaded for the state being entered so plot lines up with the state.
    always_comb begin
        plot_d   = (state_d == StErase) || (state_d == StDraw);
        x_d      = '0;
        y_d      = '0;
        colour_d = '0;
        if (plot_d) begin
            x_d      = ox_d[idx_d] + {6'd0, cnt_d[1:0]};
            y_d      = oy_d[idx_d] + {5'd0, cnt_d[3:2]};
            colour_d = (state_d == StDraw) ? 3'b100 : 3'b000;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = (state_q != StIdle);
    assign hit    = hit_q;
    assign score  = score_q;

endmodule

// File: tb/tb_obstacle_engine.sv
// Directed bench for obstacle_engine: pass timing, pixel stream, respawn, collision, resets and
// score saturation (second instance with a short screen so respawns come every two frames).
module tb_obstacle_engine;

    logic       clock;
    logic       reset;
    logic       frame, frame2;
    logic       enable;
    logic [7:0] player_x;
    logic [6:0] player_y;
    logic [7:0] x, x2;
    logic [6:0] y, y2;
    logic [2:0] colour, colour2;
    logic       plot, plot2, busy, busy2, hit, hit2;
    logic [7:0] score, score2;

    int n_total = 0;
    int n_bad   = 0;

    obstacle_engine dut (
        .clock    (clock),
        .reset    (reset),
        .frame    (frame),
        .enable   (enable),
        .player_x (player_x),
        .player_y (player_y),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .hit      (hit),
        .score    (score)
    );

    obstacle_engine #(
        .NUM_OBS    (1),
        .FALL_SPEED (4),
        .SCREEN_H   (8)
    ) dut_sat (
        .clock    (clock),
        .reset    (reset),
        .frame    (frame2),
        .enable   (enable),
        .player_x (player_x),
        .player_y (player_y),
        .x        (x2),
        .y        (y2),
        .colour   (colour2),
        .plot     (plot2),
        .busy     (busy2),
        .hit      (hit2),
        .score    (score2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded 8'hA5, steps every clock out of reset.
    logic [7:0] m_lfsr;
    always @(posedge clock or posedge reset) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    logic [7:0] log_x [0:255];
    logic [6:0] log_y [0:255];
    logic [2:0] log_c [0:255];
    logic       log_p [0:255];
    logic [7:0] log_s [0:255];
    logic [7:0] log_l [0:255];
    int n_plot, n_busy, n_oor;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse frame, then log one sample per cycle until busy drops (bounded).
    task automatic do_pass(input int refire);
        n_plot = 0;
        n_busy = 0;
        @(negedge clock) frame = 1'b1;
        @(negedge clock) frame = 1'b0;
        for (int k = 0; k < 250; k++) begin
            frame = (k == refire);
            log_x[k] = x;
            log_y[k] = y;
            log_c[k] = colour;
            log_p[k] = plot;
            log_s[k] = score;
            log_l[k] = m_lfsr;
            if (plot) begin
                n_plot++;
                if (x > 8'd159 || y > 7'd119) n_oor++;
            end
            if (!busy) break;
            n_busy++;
            @(negedge clock);
        end
        frame = 1'b0;
        check("pass_end_busy", int'(busy), 0);
    endtask

    task automatic watch_idle(input bit pulse, input string tag);
        int act;
        act = 0;
        if (pulse) begin
            @(negedge clock) frame = 1'b1;
            @(negedge clock) frame = 1'b0;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (plot || busy) act++;
        end
        check(tag, act, 0);
    endtask

    initial begin
        int exp_x3;
        int stuck;
        reset    = 1'b1;
        frame    = 1'b0;
        frame2   = 1'b0;
        enable   = 1'b1;
        player_x = 8'd0;
        player_y = 7'd100;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_score", int'(score), 0);
        reset = 1'b0;
        @(negedge clock);

        // Collision: obstacle 1 at x=52 falls from y=30
        player_x = 8'd52;
        player_y = 7'd40;
        do_pass(-1);
        check("hit1_obs1_x", int'(log_x[50]), 52);
        check("hit1_obs1_y", int'(log_y[50]), 31);
        check("hit1_flag", int'(hit), 0);
        player_y = 7'd33;
        do_pass(-1);
        check("hit2_obs1_y", int'(log_y[50]), 32);
        check("hit2_plots", n_plot, 128);
        check("hit2_flag", int'(hit), 1);
        watch_idle(1'b1, "hit_blocks_pass");

        // Frame pulse mid-pass is dropped
        reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        player_x = 8'd0;
        player_y = 7'd100;
        do_pass(10);
        check("refire_busy", n_busy, 132);
        check("refire_plots", n_plot, 128);
        watch_idle(1'b0, "refire_no_second");
        enable = 1'b0;
        watch_idle(1'b1, "enable_low_blocks");
        enable = 1'b1;

        // Asynchronous reset 50 cycles into a pass
        @(negedge clock) frame = 1'b1;
        @(negedge clock) frame = 1'b0;
        repeat (50) @(negedge clock);
        check("pre_rst_plot", int'(plot), 1);
        reset = 1'b1;
        #1;
        check("midrst_plot", int'(plot), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_score", int'(score), 0);
        @(negedge clock) reset = 1'b0;

        // 30-frame run, player clear of every obstacle
        n_oor  = 0;
        exp_x3 = 124;
        for (int f = 1; f <= 30; f++) begin
            do_pass(-1);
            if (f == 1) begin
                check("f1_plots", n_plot, 128);
                check("f1_busy", n_busy, 132);
                check("f1_e0_x", int'(log_x[0]), 16);
                check("f1_e0_y", int'(log_y[0]), 0);
                check("f1_e0_c", int'(log_c[0]), 0);
                check("f1_e0_p", int'(log_p[0]), 1);
                check("f1_e15_x", int'(log_x[15]), 19);
                check("f1_e15_y", int'(log_y[15]), 3);
                check("f1_move_p", int'(log_p[16]), 0);
                check("f1_move_x", int'(log_x[16]), 0);
                check("f1_d0_x", int'(log_x[17]), 16);
                check("f1_d0_y", int'(log_y[17]), 1);
                check("f1_d0_c", int'(log_c[17]), 4);
                check("f1_d15_x", int'(log_x[32]), 19);
                check("f1_d15_y", int'(log_y[32]), 4);
                check("f1_e_obs1_x", int'(log_x[33]), 52);
                check("f1_e_obs1_y", int'(log_y[33]), 30);
            end
            if (f == 27) begin
                exp_x3 = (log_l[115] >= 8'd156) ? int'(log_l[115]) - 156 : int'(log_l[115]);
                check("resp_score_before", int'(log_s[115]), 0);
                check("resp_score_after", int'(log_s[116]), 1);
                check("resp_x_le155", int'(log_x[116] <= 8'd155), 1);
            end
            check($sformatf("obs3_y_f%0d", f), int'(log_y[116]), (f < 27) ? 90 + f : f - 27);
            check($sformatf("obs3_x_f%0d", f), int'(log_x[116]), exp_x3);
            check($sformatf("score_f%0d", f), int'(score), (f >= 27) ? 1 : 0);
        end
        check("run_out_of_range", n_oor, 0);
        check("run_hit", int'(hit), 0);

        // Score saturation on the short-screen instance: one respawn every two frames
        stuck = 0;
        for (int f = 1; f <= 520; f++) begin
            @(negedge clock) frame2 = 1'b1;
            @(negedge clock) frame2 = 1'b0;
            for (int k = 0; k < 60 && busy2; k++) @(negedge clock);
            if (busy2) stuck++;
            if (f == 2)   check("sat_f2", int'(score2), 1);
            if (f == 508) check("sat_f508", int'(score2), 254);
            if (f == 510) check("sat_f510", int'(score2), 255);
            if (f == 520) check("sat_f520", int'(score2), 255);
        end
        check("sat_pass_timeout", stuck, 0);
        check("sat_hit", int'(hit2), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
